axi_mem_wr_rsp: RTL

AXI4 write-channel responder (slave) backed by a 512-bit-wide line memory. It is the far end of the memory-initialization write master: it accepts AW/W bursts, applies byte strobes to its internal memory and returns B responses. It sits in the simulation and test harness as a stand-in for device or system memory. A side read port lets the bench inspect memory contents.

---
 rtl/axi_mem_wr_rsp.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_wr_rsp.sv
// AXI4 write-channel responder backed by a 512-bit line memory.
// Accepts one AW/W burst at a time, applies byte strobes, returns a B response.
// Optional build macro AXI_MEM_WR_RSP_BP_EN gates awready/wready with an LFSR
// to inject random backpressure; the default build has no backpressure.
module axi_mem_wr_rsp #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 64
) (
    input  logic                     axis_clk,
    input  logic                     axis_rstn,
    input  logic [4:0]               s_axi_awid,
    input  logic [ADDR_W-1:0]        s_axi_awaddr,
    input  logic [7:0]               s_axi_awlen,
    input  logic [2:0]               s_axi_awsize,
    input  logic [1:0]               s_axi_awburst,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [511:0]             s_axi_wdata,
    input  logic [63:0]              s_axi_wstrb,
    input  logic                     s_axi_wlast,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [4:0]               s_axi_bid,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [$clog2(DEPTH)-1:0] dbg_rd_addr,
    output logic [511:0]             dbg_rd_data,
    output logic [31:0]              burst_cnt,
    output logic [31:0]              err_cnt
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [4:0]         id_q, id_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   line_q, line_d;
    logic               err_q, err_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [31:0]        burst_cnt_q, burst_cnt_d;
    logic [31:0]        err_cnt_q, err_cnt_d;
    logic [511:0]       dbg_rd_data_q;

    logic [511:0]       mem [DEPTH];

    logic               aw_gate;
    logic               w_gate;
    logic               aw_hs;
    logic               w_hs;
    logic               b_hs;
    logic               beat_last;
    logic               last_err;
    logic               mem_we;
    logic               aw_err;
    logic [ADDR_W-6:0]  aw_end_line;

`ifdef AXI_MEM_WR_RSP_BP_EN
    logic [15:0]        lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11, free-running every cycle
    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // LFSR state register, restarts from the fixed seed on reset
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign aw_gate = lfsr_q[0];
    assign w_gate  = lfsr_q[1];
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    assign s_axi_awready = awready_q & aw_gate;
    assign s_axi_wready  = wready_q & w_gate;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = id_q;
    assign s_axi_bresp   = err_q ? 2'b10 : 2'b00;
    assign dbg_rd_data   = dbg_rd_data_q;
    assign burst_cnt     = burst_cnt_q;
    assign err_cnt       = err_cnt_q;

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid & s_axi_wready;
    assign b_hs  = s_axi_bready & bvalid_q;

    // Wide end-line sum cannot overflow, so one compare covers both range checks
    assign aw_end_line = {1'b0, s_axi_awaddr[ADDR_W-1:6]} + {{(ADDR_W-13){1'b0}}, s_axi_awlen};

    // Classify the incoming AW request; any violation turns the burst into a sink
    always_comb begin
        aw_err = 1'b0;
        if (s_axi_awsize != 3'b110)                                aw_err = 1'b1;
        if (s_axi_awburst != 2'b01)                                aw_err = 1'b1;
        if (s_axi_awaddr[5:0] != 6'd0)                             aw_err = 1'b1;
        if (s_axi_awaddr[ADDR_W-1:6] >= (ADDR_W-6)'(DEPTH))        aw_err = 1'b1;
        if (aw_end_line >= (ADDR_W-5)'(DEPTH))                     aw_err = 1'b1;
    end

    // A beat whose wlast disagrees with the length is already part of a bad burst
    assign beat_last = (beat_q == len_q);
    assign last_err  = (s_axi_wlast != beat_last);
    assign mem_we    = w_hs & ~err_q & ~last_err;

    // Next-state and registered-output logic for the IDLE/DATA/RESP sequencer
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        beat_d      = beat_q;
        line_d      = line_q;
        err_d       = err_q;
        burst_cnt_d = burst_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = s_axi_awid;
                    len_d   = s_axi_awlen;
                    line_d  = s_axi_awaddr[6 +: IDX_W];
                    beat_d  = 8'd0;
                    err_d   = aw_err;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    line_d = line_q + IDX_W'(1);
                    beat_d = beat_q + 8'd1;
                    if (last_err) begin
                        err_d = 1'b1;
                    end
                    if (beat_last) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (b_hs) begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                    if (err_q) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                    end
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        awready_d = (state_d == IDLE);
        wready_d  = (state_d == DATA);
        bvalid_d  = (state_d == RESP);
    end

    // Control, output and debug-read registers; reset drops the burst in flight
    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q       <= IDLE;
            id_q          <= 5'd0;
            len_q         <= 8'd0;
            beat_q        <= 8'd0;
            line_q        <= '0;
            err_q         <= 1'b0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            burst_cnt_q   <= 32'd0;
            err_cnt_q     <= 32'd0;
            dbg_rd_data_q <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            len_q         <= len_d;
            beat_q        <= beat_d;
            line_q        <= line_d;
            err_q         <= err_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            burst_cnt_q   <= burst_cnt_d;
            err_cnt_q     <= err_cnt_d;
            dbg_rd_data_q <= mem[dbg_rd_addr];
        end
    end

    // Byte-strobed line write; memory contents survive reset
    always_ff @(posedge axis_clk) begin
        for (int i = 0; i < 64; i++) begin
            if (mem_we && s_axi_wstrb[i]) begin
                mem[line_q][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

endmodule
